// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional leading-zero blanking is enabled with the BIN2BCD_BLANK_EN macro.
package bin2bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int         BCD_W       = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bin2bcd_if.sv
// Start/busy/done handshake and result bus between a value source and the BCD converter.
// The blank flags exist only when BIN2BCD_BLANK_EN is defined.
interface bin2bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (output start, output bin, input busy, input done, input bcd, input blank);
  modport slave  (input start, input bin, output busy, output done, output bcd, output blank);
`else
  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
`endif
endinterface

// File: rtl/bin2bcd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] nib,
  output logic [BCD_W-1:0] nib_adj
);

  // nibbles are at most 9 here, so the 4-bit sum cannot wrap
  always_comb begin
    if (nib >= ADD3_THRESH) begin
      nib_adj = nib + 4'd3;
    end else begin
      nib_adj = nib;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Define BIN2BCD_BLANK_EN to add registered leading-zero blank flags.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  bin2bcd_if.slave   io
);

  localparam int CNT_W   = $clog2(WIDTH + 1);
  localparam int BCD_TOT = BCD_W * DIGITS;
  localparam int SR_W    = BCD_TOT + WIDTH;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [SR_W-1:0]      sr_r, sr_s, sr_adj_s, sr_shl_s;
  logic [BCD_TOT-1:0]   bcd_r, bcd_s;
  logic                 done_r, done_s;
  logic                 busy_r, busy_s;
  logic [BCD_W-1:0]     nib_adj_s [DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib     (sr_r[WIDTH + BCD_W*g +: BCD_W]),
      .nib_adj (nib_adj_s[g])
    );
  end

  // reassemble the corrected BCD field above the untouched binary field, then shift
  always_comb begin
    sr_adj_s = sr_r;
    for (int i = 0; i < DIGITS; i++) begin
      sr_adj_s[WIDTH + BCD_W*i +: BCD_W] = nib_adj_s[i];
    end
    sr_shl_s = {sr_adj_s[SR_W-2:0], 1'b0};
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_r, blank_s;

  // digit i is blank when it and every digit above it are zero; units never blank
  function automatic logic [DIGITS-1:0] lead_zero(input logic [BCD_TOT-1:0] v);
    logic [DIGITS-1:0] f;
    logic              z;
    f = {DIGITS{1'b0}};
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z    = z && (v[BCD_W*i +: BCD_W] == 4'd0);
      f[i] = z;
    end
    return f;
  endfunction
`endif

  // next-state, datapath and registered-output decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    sr_s    = sr_r;
    bcd_s   = bcd_r;
    done_s  = 1'b0;
    busy_s  = busy_r;
`ifdef BIN2BCD_BLANK_EN
    blank_s = blank_r;
`endif
    case (state_r)
      IDLE: begin
        if (io.start) begin
          state_s = SHIFT;
          cnt_s   = CNT_W'(WIDTH);
          sr_s    = {{BCD_TOT{1'b0}}, io.bin};
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end
      SHIFT: begin
        sr_s  = sr_shl_s;
        cnt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_s = IDLE;
          bcd_s   = sr_shl_s[SR_W-1 -: BCD_TOT];
          done_s  = 1'b1;
          busy_s  = 1'b0;
`ifdef BIN2BCD_BLANK_EN
          blank_s = lead_zero(sr_shl_s[SR_W-1 -: BCD_TOT]);
`endif
        end else begin
          state_s = SHIFT;
          busy_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // state, datapath and output registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      sr_r    <= {SR_W{1'b0}};
      bcd_r   <= {BCD_TOT{1'b0}};
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_r <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      sr_r    <= sr_s;
      bcd_r   <= bcd_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
`ifdef BIN2BCD_BLANK_EN
      blank_r <= blank_s;
`endif
    end
  end

  assign io.busy = busy_r;
  assign io.done = done_r;
  assign io.bcd  = bcd_r;
`ifdef BIN2BCD_BLANK_EN
  assign io.blank = blank_r;
`endif

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the multiplexed seven-segment driver (`D7S`). It turns an unsigned binary value into packed BCD digits that the driver scans onto the display. A start/busy/done handshake lets a counter or input-capture stage launch conversions. The last result is held stable between conversions so the driver always displays a coherent value.

## Interface
Parameters:
- `WIDTH`, 8: binary input width in bits.
- `DIGITS`, 3: number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH − 1; 8/3 is the shipped configuration.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  request a conversion; sampled only when idle.
- `bin`  in  WIDTH  unsigned value; captured on the accepting edge only.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; `bcd` is updated in the same cycle.
- `bcd`  out  4*DIGITS  packed result; digit 0 (units) is in [3:0]. Holds its value between conversions.
- `blank`  out  DIGITS  leading-zero flags. Present only with the macro in Configuration.

## Operation
- FSM states are IDLE and SHIFT. The iteration counter is sized for 0..WIDTH.
- IDLE:
  - If `start`=1, load shift register = {DIGITS×4'b0, `bin`}, counter = WIDTH, go to SHIFT.
  - If `start`=0, stay in IDLE.
- SHIFT, each cycle:
  - Every BCD nibble ≥5 gets +3, all nibbles in parallel.
  - Then the whole register shifts left 1.
  - Counter decrements.
- Leaving SHIFT: when the counter reaches 0 after the shift, the upper 4*DIGITS bits are written to `bcd`, `done`=1 is registered, and the FSM returns to IDLE.
- `start` while busy is ignored; no queueing. `bin` changes while busy have no effect.
- `start` held high gives back-to-back conversions.
- Nibble arithmetic is 4-bit. The add-3 is applied before the shift and never overflows, because nibbles are always ≤9 before correction.
- Output reset values: `busy`=0, `done`=0, `bcd`=0, `blank`={DIGITS{1'b1}} except bit 0 = 0. FSM resets to IDLE and the counter to 0.
- Reset mid-conversion aborts immediately. `bcd` returns to 0; no partial result is ever exposed.

## Timing
- Latency from the accepting edge to `done` is WIDTH+1 cycles. Let `start` be sampled high in IDLE at cycle N:
  - `busy`=1 during cycles N+1 … N+WIDTH.
  - `done`=1 and new `bcd` during cycle N+WIDTH+1; `busy`=0 in that cycle.
- The cycle in which `done` is high is an IDLE cycle, so a `start` there is accepted. Throughput is one conversion per WIDTH+1 cycles (9 for 8/3).
- `bcd` changes only on the edge that raises `done`. Downstream samples on `done` or reads `bcd` at any time.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `BIN2BCD_BLANK_EN`.
- Defined: `blank` port exists and is registered alongside `bcd`. `blank[i]`=1 when digit i and all higher digits are 0, for i ≥ 1. `blank[0]` is always 0, so a value of 0 shows "0". The downstream driver uses it to suppress leading zeros.
- Undefined: no `blank` port and no blanking logic; the driver shows all digits.

## Structure
- Package `bin2bcd_pkg` holds:
  - the state enum type (IDLE, SHIFT);
  - `BCD_W`=4;
  - `ADD3_THRESH`=4'd5.
- Sub-module `bcd_add3`: combinational 4-bit correction cell, outputs in+3 when in ≥5, else in. Instantiated DIGITS times with a generate loop.
- The top level contains the FSM, counter, shift register, result register and optional blanking.

## Test plan
- Reset, then `bin`=255 with `start` pulsed for one cycle → `busy` high for 8 cycles, `done` 9 cycles after the start edge, `bcd`=12'h255.
- `bin`=0 → `bcd`=12'h000. `bin`=99 → `bcd`=12'h099. With the macro, 99 gives `blank`=3'b100 and 0 gives `blank`=3'b110.
- `start` pulsed again at cycle 3 of a conversion of 200, with `bin`=17 → ignored. Result 12'h200, single `done` pulse.
- `start` held high with `bin` stepping 9, 10, 128 → `done` every 9 cycles, with `bcd` 12'h009, 12'h010, 12'h128 in order.
- `rst_n` asserted at cycle 4 of a conversion after a prior result of 12'h042 → outputs go to reset values at once. No `done` follows; the next conversion of 7 gives 12'h007.
- Exhaustive sweep of 0…255 against a reference model → every `bcd` matches decimal, exactly one `done` per accepted start.
